// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states,
// iteration count and small op-decode helpers.
package md_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned ITER     = MD_WIDTH;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } md_state_e;

  function automatic logic op_is_calc(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_abs.sv
// Combinational conditional two's-complement negate, used both for operand
// magnitudes and for the final sign fix-up of results.
module md_abs #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] in_val,
  input  logic             neg,
  output logic [Width-1:0] out_val
);

  assign out_val = neg ? ((~in_val) + Width'(1)) : in_val;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with private HI/LO registers: one shift-add or
// restoring shift-subtract step per cycle, then a single sign fix-up cycle.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = ITER
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  md_state_e          state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div_q;
  logic               neg_q;
  logic               sign_a_q;
  logic               divz_q;
  logic               busy_q;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_tmp;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign sign_a = op_is_signed(Op) & A[WIDTH-1];
  assign sign_b = op_is_signed(Op) & B[WIDTH-1];

  md_abs #(.Width(WIDTH)) u_abs_a (
    .in_val  (A),
    .neg     (sign_a),
    .out_val (mag_a)
  );

  md_abs #(.Width(WIDTH)) u_abs_b (
    .in_val  (B),
    .neg     (sign_b),
    .out_val (mag_b)
  );

  md_abs #(.Width(2 * WIDTH)) u_fix_prod (
    .in_val  (acc_q),
    .neg     (neg_q),
    .out_val (prod_fix)
  );

  md_abs #(.Width(WIDTH)) u_fix_quo (
    .in_val  (acc_q[WIDTH-1:0]),
    .neg     (neg_q),
    .out_val (quo_fix)
  );

  // Remainder follows the sign of the dividend, not the quotient.
  md_abs #(.Width(WIDTH)) u_fix_rem (
    .in_val  (acc_q[2*WIDTH-1:WIDTH]),
    .neg     (sign_a_q),
    .out_val (rem_fix)
  );

  // Multiply: accumulator holds {partial product, remaining multiplier bits}.
  // Divide:   accumulator holds {partial remainder, dividend/quotient bits}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_b_q};
    div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_tmp - {1'b0, mag_b_q};
    acc_iter = acc_q;
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_iter = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_iter = {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else if (acc_q[0]) begin
      acc_iter = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      acc_iter = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      divz_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (Flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            if (op_is_calc(Op)) begin
              acc_q    <= {{WIDTH{1'b0}}, mag_a};
              mag_b_q  <= mag_b;
              is_div_q <= op_is_div(Op);
              neg_q    <= sign_a ^ sign_b;
              sign_a_q <= sign_a;
              divz_q   <= (B == '0);
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= StCalc;
            end else if (Op == MD_MTHI) begin
              hi_q <= A;
            end else if (Op == MD_MTLO) begin
              lo_q <= A;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_iter;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (is_div_q) begin
            if (!divz_q) begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit with its own HI/LO registers. It sits directly downstream of the register file. It takes the two operand read ports (rs → A, rt → B) in the EX stage and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI and LO are exposed to the EX-stage result mux for MFHI/MFLO. While an operation is in flight it raises Busy, which the hazard unit uses to stall any following mult/div/mf/mt instruction.

## Interface
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- Start  in  1  EX-stage instruction is a md op; sampled only while Busy=0.
- Op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6/7 = no operation.
- A  in  WIDTH  rs operand (register file read port 1).
- B  in  WIDTH  rt operand (register file read port 2).
- Flush  in  1  pipeline flush on exception/interrupt; aborts the current operation.
- Busy  out  1  operation in flight.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

## Operation
- Reset values: state IDLE, Busy=0, HI=0, LO=0, counter=0.
- States:
  - IDLE: Start=1 with Op 0–3 latches |A|, |B|, signs and op, then goes to CALC with cnt=0. For unsigned ops the magnitude is the raw value.
  - IDLE: Start=1 with Op 4 or 5 writes A into HI or LO at that edge and stays in IDLE; Busy stays 0.
  - CALC: performs one iteration per cycle, cnt 0..WIDTH-1.
    - Multiply: shift-add on a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - After iteration WIDTH-1, goes to FIX.
  - FIX: applies the sign, writes HI/LO, returns to IDLE.
- Sign rules:
  - Signed product is negated when sign(A)≠sign(B).
  - Signed quotient is negated when sign(A)≠sign(B); the remainder takes the sign of A.
  - 0x80000000 / −1 gives LO=0x80000000, HI=0.
- Results:
  - Multiply writes HI = product[2W-1:W] and LO = product[W-1:0].
  - Divide writes LO = quotient and HI = remainder.
- Divide by zero (B=0): full latency is still taken; HI and LO are left unchanged.
- Start while Busy=1: ignored; the latched operands are unaffected.
- Flush in any state: next state is IDLE and HI/LO are not written. Flush and Start in the same cycle: Flush wins and nothing is latched.
- Rst_n asserted mid-operation: immediate return to the reset values.

## Timing
- Start is sampled at edge E0. Iterations occur at E1..E32 and FIX at E33. HI/LO hold the new value after E33.
- Busy is high from after E0 through E33: exactly WIDTH+1 = 33 cycles.
- An MFHI/MFLO issued in the cycle after Busy falls sees the new result. No bypass of in-flight results exists.
- MTHI/MTLO take effect at E0; HI/LO are readable in the next cycle.
- Back-to-back operations: a new Start is accepted in the first cycle Busy=0.

## Structure
- md_pkg holds:
  - Op encodings (MD_MULT..MD_MTLO).
  - State encoding (IDLE, CALC, FIX).
  - ITER = WIDTH.
- Sub-module md_abs: a combinational WIDTH-bit conditional negate (out = neg ? −in : in). It is instantiated for operand magnitudes at Start and for result sign fix-up in FIX.
- Counter width is clog2(WIDTH).
- The accumulator is shared between the multiply and divide paths.

## Test plan
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF:
  - Busy is high for 33 cycles.
  - Result HI=0xFFFFFFFE, LO=0x00000001.
- MULT, A=−3, B=7: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Divide cases:
  - DIV, A=−7, B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU, A=7, B=2: LO=3, HI=1.
  - DIV, A=0x80000000, B=−1: LO=0x80000000, HI=0.
- Divide by zero: MTHI 0x1234, then MTLO 0x5678, then DIVU A=9, B=0.
  - Busy is high for 33 cycles.
  - HI=0x1234, LO=0x5678 are unchanged.
- Flush and ignored requests:
  - MULTU 5×6, with Flush asserted at iteration 10: Busy=0 the next cycle and HI/LO keep their prior values.
  - Start with new operands during Busy is ignored; the result equals the first operation's result.
- Reset and idle writes:
  - Rst_n low mid-DIV: Busy, HI and LO are 0 immediately.
  - MTLO 0xABCD issued while idle: LO=0xABCD the next cycle and Busy stays 0.
